// File: rtl/cmp_sampler_pkg.sv
// Shared types and helpers for the cmp_sampler_array comparator block.
// The optional CMP_TIE_FLAG_EN macro does not affect this package.
package cmp_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DEC_LOW  = 2'b00,
    DEC_HIGH = 2'b01,
    DEC_TIE  = 2'b10
  } dec_e;

  // Width of a counter that must hold values 0..filter_len.
  function automatic int cnt_w(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/cmp_sampler_array_if.sv
// Change-event handshake bundle of cmp_sampler_array.
// Optional macro CMP_TIE_FLAG_EN adds the sticky evt_tie flag.
interface cmp_sampler_array_if #(
  parameter int CHANNELS = 4
);
  logic                evt_valid;
  logic                evt_ready;
  logic [CHANNELS-1:0] evt_data;
  logic [CHANNELS-1:0] evt_mask;
  logic                evt_ovf;
`ifdef CMP_TIE_FLAG_EN
  logic                evt_tie;
`endif

  modport master (
    output evt_valid,
    output evt_data,
    output evt_mask,
    output evt_ovf,
`ifdef CMP_TIE_FLAG_EN
    output evt_tie,
`endif
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_mask,
    input  evt_ovf,
`ifdef CMP_TIE_FLAG_EN
    input  evt_tie,
`endif
    output evt_ready
  );
endinterface

// File: rtl/cmp_chan_filter.sv
// One comparator channel: rail synchroniser, tick decision and agreement filter.
// Optional macro CMP_TIE_FLAG_EN exposes the per-channel tie decision.
module cmp_chan_filter
  import cmp_sampler_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic tick_i,
  input  logic vip_i,
  input  logic vin_i,
  output logic dout_o,
  output logic flip_o
`ifdef CMP_TIE_FLAG_EN
  ,
  output logic tie_o
`endif
);
  localparam int CW = cnt_w(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sp_q;
  logic [SYNC_STAGES-1:0] sn_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   val_q;
  logic                   val_d;
  logic                   dout_q;
  logic                   flip_d;
  logic                   dec_hi_s;
  dec_e                   dec_s;

  // Resolve the synchronised dual-rail pair into a decision.
  always_comb begin
    case ({sp_q[SYNC_STAGES-1], sn_q[SYNC_STAGES-1]})
      2'b10:   dec_s = DEC_HIGH;
      2'b01:   dec_s = DEC_LOW;
      default: dec_s = DEC_TIE;
    endcase
  end

  assign dec_hi_s = (dec_s == DEC_HIGH);

  // Candidate counter: a tie leaves the candidate untouched.
  always_comb begin
    cnt_d  = cnt_q;
    val_d  = val_q;
    flip_d = 1'b0;
    if (tick_i && (dec_s != DEC_TIE)) begin
      if (dec_hi_s == dout_q) begin
        cnt_d = '0;
      end else begin
        if (dec_hi_s == val_q) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = CW'(1);
          val_d = dec_hi_s;
        end
        if (cnt_d == CW'(FILTER_LEN)) begin
          flip_d = 1'b1;
          cnt_d  = '0;
        end else begin
          flip_d = 1'b0;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchroniser and filter state; clr_i flushes all but the decision itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q   <= '0;
      sn_q   <= '0;
      cnt_q  <= '0;
      val_q  <= 1'b0;
      dout_q <= 1'b0;
    end else if (clr_i) begin
      sp_q   <= '0;
      sn_q   <= '0;
      cnt_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      sp_q   <= {sp_q[SYNC_STAGES-2:0], vip_i};
      sn_q   <= {sn_q[SYNC_STAGES-2:0], vin_i};
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      dout_q <= dout_q ^ flip_d;
    end
  end

  assign dout_o = dout_q;
  assign flip_o = flip_d;
`ifdef CMP_TIE_FLAG_EN
  assign tie_o  = (dec_s == DEC_TIE);
`endif

endmodule

// File: rtl/cmp_sampler_array.sv
// Multi-channel comparator sampler: enable FSM, sample prescaler and change-event handshake.
// Optional macro CMP_TIE_FLAG_EN adds tie_flag and evt_tie reporting.
module cmp_sampler_array
  import cmp_sampler_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int DIV_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DIV_W-1:0]    div,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
`ifdef CMP_TIE_FLAG_EN
  output logic [CHANNELS-1:0] tie_flag,
`endif
  output logic [CHANNELS-1:0] dout,
  cmp_sampler_array_if.master evt
);
  localparam int AW = $clog2(SYNC_STAGES + 1);

  state_e              state_q;
  logic [AW-1:0]       arm_q;
  logic [DIV_W-1:0]    pre_q;
  logic [DIV_W-1:0]    per_q;
  logic                tick_s;
  logic                clr_s;
  logic                acc_s;
  logic [CHANNELS-1:0] dout_s;
  logic [CHANNELS-1:0] flip_s;
  logic [CHANNELS-1:0] dout_new_s;
  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic                ovf_q, ovf_d;

  assign tick_s = (state_q == RUN) && (pre_q == per_q);
  assign clr_s  = (state_q == IDLE);

  // Enable FSM and prescaler; the period register reloads from div at every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      arm_q   <= '0;
      pre_q   <= '0;
      per_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          arm_q <= '0;
          pre_q <= '0;
          if (en) state_q <= ARM;
          else    state_q <= IDLE;
        end
        ARM: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (arm_q == AW'(SYNC_STAGES - 1)) begin
            state_q <= RUN;
            pre_q   <= '0;
            per_q   <= div;
          end else begin
            arm_q <= arm_q + AW'(1);
          end
        end
        RUN: begin
          if (!en) begin
            state_q <= IDLE;
            pre_q   <= '0;
          end else if (tick_s) begin
            pre_q <= '0;
            per_q <= div;
          end else begin
            pre_q <= pre_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
`ifdef CMP_TIE_FLAG_EN
    logic tie_s;
`endif
    cmp_chan_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (clr_s),
      .tick_i (tick_s),
      .vip_i  (vip[g]),
      .vin_i  (vin[g]),
      .dout_o (dout_s[g]),
      .flip_o (flip_s[g])
`ifdef CMP_TIE_FLAG_EN
      ,
      .tie_o  (tie_s)
`endif
    );
  end

  assign dout_new_s = dout_s ^ flip_s;
  assign acc_s      = valid_q & evt.evt_ready;

  // Event coalescing: an accepted event makes room for a same-cycle change.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ovf_d   = ovf_q;
    if (acc_s) begin
      ovf_d = 1'b0;
      if (|flip_s) begin
        mask_d = flip_s;
        data_d = dout_new_s;
      end else begin
        valid_d = 1'b0;
        mask_d  = '0;
      end
    end else if (|flip_s) begin
      valid_d = 1'b1;
      data_d  = dout_new_s;
      if (valid_q) begin
        mask_d = mask_q | flip_s;
        ovf_d  = ovf_q | (|(flip_s & mask_q));
      end else begin
        mask_d = flip_s;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout          = dout_s;
  assign evt.evt_valid = valid_q;
  assign evt.evt_data  = data_q;
  assign evt.evt_mask  = mask_q;
  assign evt.evt_ovf   = ovf_q;

`ifdef CMP_TIE_FLAG_EN
  logic [CHANNELS-1:0] tie_all_s;
  logic [CHANNELS-1:0] tie_flag_q;
  logic                evt_tie_q;

  for (genvar t = 0; t < CHANNELS; t++) begin : g_tie
    assign tie_all_s[t] = g_ch[t].tie_s;
  end

  // Tie reporting: per-channel flag refreshed each tick, sticky summary until acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_flag_q <= '0;
      evt_tie_q  <= 1'b0;
    end else begin
      if (tick_s) tie_flag_q <= tie_all_s;
      else        tie_flag_q <= tie_flag_q;
      evt_tie_q <= (acc_s ? 1'b0 : evt_tie_q) | (tick_s & (|tie_all_s));
    end
  end

  assign tie_flag    = tie_flag_q;
  assign evt.evt_tie = evt_tie_q;
`endif

endmodule

// File: doc/cmp_sampler_array.md
Name: cmp_sampler_array

Overview:
Multi-channel successor to the single regenerative comparator cell. Each channel takes a digital dual-rail pair (vip/vin), synchronises it, and resolves it on a programmable sample tick. A tie (vip==vin) holds the previous decision, matching the cell's hold-when-not-enabled behaviour. A consecutive-agreement filter qualifies each decision, and changes are reported as events through a valid/ready handshake.

Parameters:
CHANNELS, 4, number of independent comparator channels (1..8)
SYNC_STAGES, 2, synchroniser flops per input rail (>=2)
FILTER_LEN, 3, consecutive agreeing non-tie samples required to flip an output (1..15)
DIV_W, 8, width of sample-period divider

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; low forces IDLE
div  in  DIV_W  sample period = div+1 clk cycles
vip  in  CHANNELS  positive rail per channel, asynchronous
vin  in  CHANNELS  negative rail per channel, asynchronous
dout  out  CHANNELS  filtered decision per channel
evt_valid  out  1  change event pending
evt_ready  in  1  consumer accepts event
evt_data  out  CHANNELS  dout snapshot for the event
evt_mask  out  CHANNELS  channels changed since last accepted event
evt_ovf  out  1  sticky: a channel changed twice while an event was pending

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state clears on rst_n low, with no clock required.
- Reset values: dout=0, evt_valid=0, evt_data=0, evt_mask=0, evt_ovf=0, FSM=IDLE, prescaler=0, filter counters=0.
- FSM states:
  - IDLE: en=0. Prescaler, filter counters and synchronisers are held cleared. dout holds. A pending event stays pending.
  - ARM: entered when en rises. Lasts SYNC_STAGES cycles to flush the synchronisers. No ticks are generated.
  - RUN: prescaler counts 0..div. A tick fires on the cycle the count equals div, and the count reloads to 0.
  - Transitions: en=0 in any state goes to IDLE on the next edge, and a partial filter count is discarded.
- div is sampled at each reload, so a mid-run change takes effect after the current period. div=0 gives a tick every RUN cycle.
- Decision per channel at tick, from synchronised rails: vip=1,vin=0 is HIGH; vip=0,vin=1 is LOW; equal is TIE.
- Filter per channel:
  - A non-tie decision different from dout increments cand_cnt if it matches cand_val; otherwise cand_cnt=1 and cand_val=decision.
  - A decision equal to dout clears cand_cnt.
  - TIE leaves cand_cnt and cand_val unchanged.
  - When cand_cnt reaches FILTER_LEN, dout flips on the next edge and cand_cnt clears.
- Latency: a rail change is visible to the filter after SYNC_STAGES cycles. dout flips one cycle after the FILTER_LEN-th qualifying tick.
- Events, in the cycle dout changes (chg = changed channels):
  - If evt_valid=0: evt_valid=1, evt_mask=chg, evt_data=new dout.
  - If evt_valid=1 and not accepted: evt_mask|=chg and evt_data=new dout. evt_ovf sets if chg&evt_mask!=0.
  - Accepted (valid&ready) with simultaneous chg: the new event loads with evt_mask=chg only; evt_valid stays 1.
  - Accepted with no chg: evt_valid=0, evt_mask=0.
- evt_ovf clears only on reset or on an acceptance that has no simultaneous overflow.
- evt_valid must not drop without acceptance, except on reset.

Optional Feature:
CMP_TIE_FLAG_EN:
- Defined: adds output port tie_flag (CHANNELS wide, reset 0), updated at each tick to 1 where that channel's decision was TIE. It also adds evt_tie (1 bit, sticky until the next acceptance), set when any tick produced a TIE.
- Undefined: these ports are absent and ties silently hold state. All other behaviour is identical.

Decomposition:
- Package cmp_sampler_pkg holds:
  - state enum {IDLE, ARM, RUN}
  - decision encoding DEC_LOW=2'b00, DEC_HIGH=2'b01, DEC_TIE=2'b10
  - filter counter width function clog2(FILTER_LEN+1)
- One sub-module, cmp_chan_filter, instantiated CHANNELS times. It contains the synchroniser, decision logic, candidate counter and dout register. The top level holds the FSM, prescaler and event/handshake logic.

Test Plan:
- Reset mid-RUN with evt_valid=1: assert rst_n=0 asynchronously -> all outputs 0 within the same cycle, FSM=IDLE.
- div=3, FILTER_LEN=3, ch0 vip=1,vin=0 stable after ARM -> dout[0]=1 at first tick+8 cycles+1. evt_valid=1, evt_mask=4'b0001, evt_data=4'b0001.
- ch1 goes HIGH for 2 ticks, then TIE for 2 ticks, then HIGH for 1 tick -> dout[1] flips on the 3rd HIGH tick. A LOW interposed instead restarts the count (no flip).
- evt_ready=0 and ch0 toggles 1->0->1 -> evt_mask=0001, evt_ovf=1, evt_data reflects latest dout. Then evt_ready=1 for one cycle -> evt_valid=0, evt_ovf=0.
- Acceptance in the same cycle as a ch2 flip -> evt_valid stays 1, evt_mask=0100.
- en dropped after 2 qualifying ticks then restored -> filter restarts. dout unchanged until 3 fresh ticks after ARM completes.
